uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART encodings for the transmit and receive ends.
// Holds the frame states, parity codes and the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int bit_cyc_calc(input int baud, input int fqc);
        return fqc / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit timer: counts 0..BIT_CYC-1 and flags the last cycle of a bit.
// Cleared synchronously when a new frame starts.
module uart_baud_cnt #(
    parameter int BIT_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BIT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing with optional odd/even parity.
// tx is a registered output; the next line level is decided a cycle early.
module uart_tx
    import uart_pkg::*;
#(
    parameter int TX_BAUD = 9600,
    parameter int CLK_FQC = 50_000_000,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    localparam int BIT_CYC = bit_cyc_calc(TX_BAUD, CLK_FQC);

    generate
        if (BIT_CYC < 2 || PARITY > 2) begin : g_bad_cfg
            $error("uart_tx: BIT_CYC must be >= 2 and PARITY <= 2");
        end
    endgenerate

    uart_state_t state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        tick;
    logic        accept;

    function automatic logic par_of(input logic [7:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign ready  = (state_q == ST_IDLE) ||
                    (state_q == ST_STOP && tick);
    assign done   = (state_q == ST_STOP) && tick;
    assign accept = valid && ready;
    assign tx     = tx_q;

    uart_baud_cnt #(
        .BIT_CYC(BIT_CYC)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (state_q != ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        tx_d    = tx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    sh_d    = data;
                    par_d   = par_of(data);
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                // Final stop cycle doubles as an accept slot for back-to-back frames
                if (tick) begin
                    if (accept) begin
                        state_d = ST_START;
                        sh_d    = data;
                        par_d   = par_of(data);
                        idx_d   = '0;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity) with a line decoder
// feeding a per-instance scoreboard of expected {parity, byte} frames.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       ready [3];
    logic       tx    [3];
    logic       done  [3];

    int checks = 0;
    int fails  = 0;

    logic [8:0]  exp_q [3][$];
    logic        busy  [3];
    logic        prev  [3];
    int          bc    [3];
    logic [10:0] bits  [3];
    int          last_start [3];
    int          prev_start [3];
    int          done_cnt   [3];
    int          cyc = 0;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       par;
    } vec_t;

    vec_t tv [10];

    always #10 clk = ~clk;

    uart_tx #(.TX_BAUD(1_000_000), .CLK_FQC(50_000_000), .PARITY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(data[0]), .valid(valid[0]),
        .ready(ready[0]), .tx(tx[0]), .done(done[0]));

    uart_tx #(.TX_BAUD(1_000_000), .CLK_FQC(50_000_000), .PARITY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data[1]), .valid(valid[1]),
        .ready(ready[1]), .tx(tx[1]), .done(done[1]));

    uart_tx #(.TX_BAUD(1_000_000), .CLK_FQC(50_000_000), .PARITY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(data[2]), .valid(valid[2]),
        .ready(ready[2]), .tx(tx[2]), .done(done[2]));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rx_check(input int i, input logic [10:0] b);
        logic [8:0] e;
        int nb;
        nb = (i == 0) ? 9 : 10;
        chk($sformatf("rx_frame_expected[%0d]", i), exp_q[i].size() != 0, 1);
        if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("rx_start[%0d]", i), b[0], 1'b0);
            chk($sformatf("rx_data[%0d]", i), b[8:1], e[7:0]);
            if (i != 0) chk($sformatf("rx_parity[%0d]", i), b[9], e[8]);
            chk($sformatf("rx_stop[%0d]", i), b[nb], 1'b1);
        end
    endtask

    // Samples each line mid-bit, starting from the first low sample
    task automatic rx_monitor();
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                int nb;
                int k;
                nb = (i == 0) ? 9 : 10;
                if (!rst_n) begin
                    busy[i] = 1'b0;
                    prev[i] = 1'b1;
                end else begin
                    if (done[i]) done_cnt[i]++;
                    if (!busy[i]) begin
                        if (prev[i] && !tx[i]) begin
                            busy[i] = 1'b1;
                            bc[i] = 0;
                            prev_start[i] = last_start[i];
                            last_start[i] = cyc;
                        end
                    end else begin
                        bc[i]++;
                    end
                    if (busy[i] && (bc[i] % 50) == 25) begin
                        k = bc[i] / 50;
                        bits[i][k] = tx[i];
                        if (k == nb) begin
                            busy[i] = 1'b0;
                            rx_check(i, bits[i]);
                        end
                    end
                    prev[i] = tx[i];
                end
            end
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic p);
        int c;
        c = 0;
        @(negedge clk);
        while (!ready[i] && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("ready_wait", ready[i], 1'b1);
        data[i]  = d;
        valid[i] = 1'b1;
        exp_q[i].push_back({p, d});
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
        data[i]  = ~d;
    endtask

    task automatic wait_done(input int i, output int n);
        n = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (done[i]) begin
                n = c;
                return;
            end
        end
    endtask

    initial begin
        int n;
        int dc;
        int flen;

        tv[0] = '{0, 8'hAF, 1'b0};
        tv[1] = '{0, 8'h00, 1'b0};
        tv[2] = '{0, 8'hFF, 1'b0};
        tv[3] = '{1, 8'h56, 1'b1};
        tv[4] = '{2, 8'h56, 1'b0};
        tv[5] = '{1, 8'h00, 1'b1};
        tv[6] = '{2, 8'h01, 1'b1};
        tv[7] = '{1, 8'hFF, 1'b1};
        tv[8] = '{2, 8'hFF, 1'b0};
        tv[9] = '{1, 8'h80, 1'b0};

        for (int i = 0; i < 3; i++) begin
            data[i] = '0;
            valid[i] = 1'b0;
            busy[i] = 1'b0;
            prev[i] = 1'b1;
            bc[i] = 0;
            bits[i] = '0;
            last_start[i] = 0;
            prev_start[i] = 0;
            done_cnt[i] = 0;
        end

        fork
            rx_monitor();
        join_none

        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("reset_tx", tx[i], 1'b1);
                chk("reset_ready", ready[i], 1'b1);
                chk("reset_done", done[i], 1'b0);
            end
        end
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            dc = done_cnt[tv[t].inst];
            flen = (tv[t].inst == 0) ? 500 : 550;
            send(tv[t].inst, tv[t].d, tv[t].par);
            wait_done(tv[t].inst, n);
            chk($sformatf("done_latency[%0d]", t), n, flen);
            @(negedge clk);
            #1;
            chk($sformatf("done_count[%0d]", t), done_cnt[tv[t].inst], dc + 1);
            chk($sformatf("idle_ready[%0d]", t), ready[tv[t].inst], 1'b1);
            chk($sformatf("idle_tx[%0d]", t), tx[tv[t].inst], 1'b1);
            chk($sformatf("queue_empty[%0d]", t), exp_q[tv[t].inst].size(), 0);
        end

        // Back-to-back with valid held across both acceptances
        dc = done_cnt[0];
        @(negedge clk);
        data[0] = 8'hAF;
        valid[0] = 1'b1;
        exp_q[0].push_back({1'b0, 8'hAF});
        @(posedge clk);
        #1;
        data[0] = 8'h56;
        exp_q[0].push_back({1'b0, 8'h56});
        wait_done(0, n);
        chk("b2b_first_done", n, 500);
        chk("b2b_ready_in_stop", ready[0], 1'b1);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        wait_done(0, n);
        chk("b2b_second_done", n, 500);
        @(negedge clk);
        #1;
        chk("b2b_no_gap", last_start[0] - prev_start[0], 500);
        chk("b2b_done_count", done_cnt[0], dc + 2);
        chk("b2b_queue_empty", exp_q[0].size(), 0);

        // Reset during data bit 3, with valid asserted in reset
        dc = done_cnt[0];
        send(0, 8'hAF, 1'b0);
        repeat (226) @(negedge clk);
        #2;
        rst_n = 1'b0;
        data[0] = 8'h56;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx", tx[0], 1'b1);
        chk("midrst_ready", ready[0], 1'b1);
        chk("midrst_done", done[0], 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        valid[0] = 1'b0;
        chk("midrst_pending", exp_q[0].size(), 1);
        void'(exp_q[0].pop_front());
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_accept", tx[0], 1'b1);
        send(0, 8'h56, 1'b0);
        wait_done(0, n);
        chk("midrst_resend_done", n, 500);
        @(negedge clk);
        #1;
        chk("midrst_done_count", done_cnt[0], dc + 1);
        chk("midrst_queue_empty", exp_q[0].size(), 0);

        // valid pulsed mid-frame must be ignored
        dc = done_cnt[0];
        send(0, 8'h3C, 1'b0);
        repeat (150) @(negedge clk);
        data[0] = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        wait_done(0, n);
        chk("ign_done_latency", n, 350);
        repeat (600) @(negedge clk);
        #1;
        chk("ign_done_count", done_cnt[0], dc + 1);
        chk("ign_idle_tx", tx[0], 1'b1);
        chk("ign_queue_empty", exp_q[0].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
